icache_dm_fetch: RTL and testbench
==================================

Name: icache_dm_fetch

Overview:
- Parametrised direct-mapped L1 instruction cache for the fetch stage.
- Replaces the fixed-width, always-hit raw fetch path with a real tag/data store and a miss-handling FSM with a valid/ready memory handshake.
- Adds per-set invalidation, a walking flush sequencer and line-boundary lane truncation.
- Sits between the fetch-PC logic and the L2/memory request port.

Parameters:
FETCH_WIDTH, 4, instructions returned per fetch (1..8)
PC_BITS, 32, PC/address width
INST_BITS, 32, instruction width; instructions are 4-byte aligned
LINE_BYTES, 32, cache line size (power of 2, >= 4*FETCH_WIDTH)
NUM_SETS, 64, number of lines (power of 2)
Derived: WPL=LINE_BYTES/4; OFF=log2(LINE_BYTES); IDX=log2(NUM_SETS); TAG=PC_BITS-OFF-IDX

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
fetchReq_i  in  1  lookup request this cycle
pc_i  in  PC_BITS  fetch address; bits [1:0] ignored
laneActive_i  in  FETCH_WIDTH  per-lane enable (dynamic width)
inst_o  out  FETCH_WIDTH*INST_BITS  lane i at bits [i*INST_BITS +: INST_BITS]
instValid_o  out  FETCH_WIDTH  per-lane valid
icMiss_o  out  1  miss outstanding / cache busy
memReqAddr_o  out  PC_BITS-OFF  line address of fill request
memReqValid_o  out  1  fill request valid
memReqReady_i  in  1  memory accepts request
memRespValid_i  in  1  fill data valid
memRespAddr_i  in  PC_BITS-OFF  line address of returned data
memRespData_i  in  LINE_BYTES*8  line data, word 0 in LSBs
inv_i  in  1  invalidate one set
invIndex_i  in  IDX  set to invalidate
flush_i  in  1  invalidate entire cache (pulse)
flushDone_o  out  1  one-cycle pulse at flush completion

Behaviour:
- Reset (async, reset==0): all valid bits 0; FSM=IDLE; instValid_o=0, icMiss_o=0, memReqValid_o=0, flushDone_o=0, inst_o=0, memReqAddr_o=0. Tag/data arrays are not reset.
- Lookup latency is 1 cycle; outputs are registered.
  - fetchReq_i at cycle t with FSM=IDLE -> result at t+1.
  - hit = valid[idx] & tag==pc tag.
  - Word offset w = pc_i[OFF-1:2].
  - instValid_o[i] = hit & laneActive_i[i](sampled at t) & (w+i < WPL).
  - inst_o lane i = word (w+i) of line; lanes beyond the line end are 0.
- No fetchReq_i, or FSM!=IDLE: instValid_o=0 next cycle.
- A miss at t gives icMiss_o=1 at t+1 and FSM goes to REQ. Fetch must re-present the PC after icMiss_o falls; no replay.
- FSM:
  - IDLE -> REQ on miss.
  - IDLE -> FLUSH on flush_i or pending flush. Flush has priority over a same-cycle miss; that fetch returns invalid with icMiss_o=1.
  - REQ: memReqValid_o=1, memReqAddr_o holds the missed line address stable until memReqReady_i. Leaves on the cycle of valid&ready.
  - REQ -> WAIT on handshake.
  - WAIT -> IDLE on memRespValid_i with memRespAddr_i == pending address. In that cycle, write data/tag and set the valid bit. Responses with a mismatched address are ignored.
  - FLUSH: counter 0..NUM_SETS-1 clears one valid bit per cycle. After the last set -> IDLE, and flushDone_o pulses in the cycle the FSM enters IDLE.
- icMiss_o is 1 in every cycle FSM!=IDLE, plus the cycle after a detected miss. It drops the cycle after the fill write.
- flush_i while in REQ/WAIT: latched as pending and executed after the fill completes. flush_i while in FLUSH is ignored.
- inv_i is applied in any state, same cycle, clearing valid[invIndex_i].
  - inv_i and fill to the same set in one cycle: invalidation wins and the line ends invalid.
  - Lookup in the same cycle as an inv_i to its set: uses pre-invalidation state.
- Reset asserted mid-miss or mid-flush aborts immediately. A late memory response after reset is ignored, because FSM=IDLE does not accept responses.

Test Plan:
- Cold miss, FW=4, LINE=32: fetch pc=0x1000 -> t+1 icMiss_o=1, memReqAddr_o=0x80; ready held low 3 cycles, address stable. Respond with words 0..7=0xA0..0xA7. Refetch 0x1000 -> instValid_o=4'b1111, lanes 0xA0..0xA3.
- Line-boundary truncation: fetch 0x1014 (w=5) on resident line -> instValid_o lanes0..2=1, lane3=0, data 0xA5,0xA6,0xA7,0.
- Lane masking: laneActive_i=4'b0011 on hit at 0x1000 -> instValid_o lanes0,1=1, lanes2,3=0.
- Flush during miss, NUM_SETS=64: flush_i pulsed in WAIT; response arrives -> fill, then 64 FLUSH cycles. flushDone_o pulses once, icMiss_o=1 throughout. A refetch of 0x1000 then misses.
- Invalidation races: inv_i with invIndex_i=0 in the fill cycle for set 0 -> subsequent fetch misses. A mismatched-address response (0x81) while pending 0x80 -> ignored, FSM stays WAIT.
- Reset mid-WAIT: assert reset -> all outputs 0 asynchronously. After release, a stale response is ignored and fetch 0x1000 misses.

Source files
------------

// File: rtl/icache_dm_fetch.sv
// Direct-mapped L1 instruction cache for the fetch stage: registered 1-cycle lookup,
// single outstanding line fill over a valid/ready port, per-set invalidate and walking flush.
module icache_dm_fetch #(
    parameter int FETCH_WIDTH = 4,
    parameter int PC_BITS     = 32,
    parameter int INST_BITS   = 32,
    parameter int LINE_BYTES  = 32,
    parameter int NUM_SETS    = 64,
    localparam int OFF        = $clog2(LINE_BYTES),
    localparam int IDX        = $clog2(NUM_SETS),
    localparam int LA         = PC_BITS - OFF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             fetchReq_i,
    input  logic [PC_BITS-1:0]               pc_i,
    input  logic [FETCH_WIDTH-1:0]           laneActive_i,
    output logic [FETCH_WIDTH*INST_BITS-1:0] inst_o,
    output logic [FETCH_WIDTH-1:0]           instValid_o,
    output logic                             icMiss_o,
    output logic [LA-1:0]                    memReqAddr_o,
    output logic                             memReqValid_o,
    input  logic                             memReqReady_i,
    input  logic                             memRespValid_i,
    input  logic [LA-1:0]                    memRespAddr_i,
    input  logic [LINE_BYTES*8-1:0]          memRespData_i,
    input  logic                             inv_i,
    input  logic [IDX-1:0]                   invIndex_i,
    input  logic                             flush_i,
    output logic                             flushDone_o
);

    localparam int WPL    = LINE_BYTES / 4;
    localparam int TAG    = PC_BITS - OFF - IDX;
    localparam int WW     = (OFF > 2) ? OFF - 2 : 1;
    localparam int LINE_W = LINE_BYTES * 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [1:0]                     state_q, state_d;
    logic [LA-1:0]                  missAddr_q, missAddr_d;
    logic                           flushPend_q, flushPend_d;
    logic [IDX-1:0]                 flushCnt_q, flushCnt_d;
    logic                           flushDone_q, flushDone_d;
    logic [NUM_SETS-1:0]            valid_q, valid_d;
    logic [FETCH_WIDTH-1:0]         instValid_q, instValid_d;
    logic [FETCH_WIDTH*INST_BITS-1:0] inst_q, inst_d;

    logic [TAG-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0] data_q [NUM_SETS];

    logic [IDX-1:0]    lkIdx;
    logic [TAG-1:0]    lkTag;
    logic [LA-1:0]     lkLine;
    logic [WW-1:0]     lkWord;
    logic              lkHit;
    logic              lookupEn;
    logic [LINE_W-1:0] lineRd;
    logic              fillEn;
    logic [IDX-1:0]    fillIdx;
    logic [TAG-1:0]    fillTag;
    logic              unusedPcBits;

    assign unusedPcBits = ^pc_i[1:0];

    assign lkIdx  = pc_i[OFF +: IDX];
    assign lkTag  = pc_i[PC_BITS-1 -: TAG];
    assign lkLine = pc_i[PC_BITS-1 -: LA];

    generate
        if (OFF > 2) begin : g_word
            assign lkWord = pc_i[OFF-1:2];
        end else begin : g_word_single
            assign lkWord = '0;
        end
    endgenerate

    // Lookup reads pre-update valid/tag state, so a same-cycle invalidate does not affect it
    assign lineRd   = data_q[lkIdx];
    assign lkHit    = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
    assign lookupEn = fetchReq_i && (state_q == ST_IDLE);

    assign fillEn  = (state_q == ST_WAIT) && memRespValid_i && (memRespAddr_i == missAddr_q);
    assign fillIdx = missAddr_q[IDX-1:0];
    assign fillTag = missAddr_q[LA-1 -: TAG];

    always_comb begin
        instValid_d = '0;
        inst_d      = '0;
        if (lookupEn && lkHit) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                for (int k = 0; k < WPL; k++) begin
                    if (int'(lkWord) + i == k) begin
                        inst_d[i*INST_BITS +: INST_BITS] = lineRd[k*INST_BITS +: INST_BITS];
                        instValid_d[i]                   = laneActive_i[i];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        missAddr_d  = missAddr_q;
        flushPend_d = flushPend_q;
        flushCnt_d  = flushCnt_q;
        flushDone_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_i || flushPend_q) begin
                    state_d     = ST_FLUSH;
                    flushCnt_d  = '0;
                    flushPend_d = 1'b0;
                end else if (lookupEn && !lkHit) begin
                    state_d    = ST_REQ;
                    missAddr_d = lkLine;
                end
            end
            ST_REQ: begin
                if (flush_i) flushPend_d = 1'b1;
                if (memReqReady_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush_i) flushPend_d = 1'b1;
                // A deferred flush starts straight from the fill so the cache never looks idle in between
                if (fillEn) begin
                    if (flushPend_q || flush_i) begin
                        state_d     = ST_FLUSH;
                        flushCnt_d  = '0;
                        flushPend_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                flushCnt_d = flushCnt_q + IDX'(1);
                if (flushCnt_q == '1) begin
                    state_d     = ST_IDLE;
                    flushDone_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Invalidate is applied last so it beats a same-cycle fill of the same set
    always_comb begin
        valid_d = valid_q;
        if (fillEn) valid_d[fillIdx] = 1'b1;
        if (state_q == ST_FLUSH) valid_d[flushCnt_q] = 1'b0;
        if (inv_i) valid_d[invIndex_i] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            missAddr_q  <= '0;
            flushPend_q <= 1'b0;
            flushCnt_q  <= '0;
            flushDone_q <= 1'b0;
            valid_q     <= '0;
            instValid_q <= '0;
            inst_q      <= '0;
        end else begin
            state_q     <= state_d;
            missAddr_q  <= missAddr_d;
            flushPend_q <= flushPend_d;
            flushCnt_q  <= flushCnt_d;
            flushDone_q <= flushDone_d;
            valid_q     <= valid_d;
            instValid_q <= instValid_d;
            inst_q      <= inst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fillEn) begin
            tag_q[fillIdx]  <= fillTag;
            data_q[fillIdx] <= memRespData_i;
        end
    end

    assign inst_o        = inst_q;
    assign instValid_o   = instValid_q;
    assign icMiss_o      = (state_q != ST_IDLE);
    assign memReqAddr_o  = missAddr_q;
    assign memReqValid_o = (state_q == ST_REQ);
    assign flushDone_o   = flushDone_q;

endmodule

// File: tb/tb_icache_dm_fetch.sv
// Directed bench for icache_dm_fetch with default parameters (FW=4, 32-byte lines, 64 sets).
module tb_icache_dm_fetch;

    logic         clk = 1'b0;
    logic         reset;
    logic         fetchReq_i;
    logic [31:0]  pc_i;
    logic [3:0]   laneActive_i;
    logic [127:0] inst_o;
    logic [3:0]   instValid_o;
    logic         icMiss_o;
    logic [26:0]  memReqAddr_o;
    logic         memReqValid_o;
    logic         memReqReady_i;
    logic         memRespValid_i;
    logic [26:0]  memRespAddr_i;
    logic [255:0] memRespData_i;
    logic         inv_i;
    logic [5:0]   invIndex_i;
    logic         flush_i;
    logic         flushDone_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_dm_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .fetchReq_i     (fetchReq_i),
        .pc_i           (pc_i),
        .laneActive_i   (laneActive_i),
        .inst_o         (inst_o),
        .instValid_o    (instValid_o),
        .icMiss_o       (icMiss_o),
        .memReqAddr_o   (memReqAddr_o),
        .memReqValid_o  (memReqValid_o),
        .memReqReady_i  (memReqReady_i),
        .memRespValid_i (memRespValid_i),
        .memRespAddr_i  (memRespAddr_i),
        .memRespData_i  (memRespData_i),
        .inv_i          (inv_i),
        .invIndex_i     (invIndex_i),
        .flush_i        (flush_i),
        .flushDone_o    (flushDone_o)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mkLine(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
        return l;
    endfunction

    task automatic fetch(input logic [31:0] pc, input logic [3:0] lanes);
        fetchReq_i   = 1'b1;
        pc_i         = pc;
        laneActive_i = lanes;
        tick();
        fetchReq_i   = 1'b0;
    endtask

    task automatic respond(input logic [26:0] addr, input logic [255:0] data);
        memRespValid_i = 1'b1;
        memRespAddr_i  = addr;
        memRespData_i  = data;
        tick();
        memRespValid_i = 1'b0;
    endtask

    task automatic handshake();
        memReqReady_i = 1'b1;
        tick();
        memReqReady_i = 1'b0;
    endtask

    initial begin
        int busyBad;
        int pulses;
        reset = 1'b1;
        fetchReq_i = 1'b0; pc_i = '0; laneActive_i = '0;
        memReqReady_i = 1'b0; memRespValid_i = 1'b0; memRespAddr_i = '0; memRespData_i = '0;
        inv_i = 1'b0; invIndex_i = '0; flush_i = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_instValid", instValid_o, 0);
        check("rst_icMiss", icMiss_o, 0);
        check("rst_memReqValid", memReqValid_o, 0);
        check("rst_flushDone", flushDone_o, 0);
        check("rst_inst", inst_o, 0);
        check("rst_memReqAddr", memReqAddr_o, 0);
        reset = 1'b1;
        tick();

        // cold miss, ready stalled for three cycles
        fetch(32'h1000, 4'hF);
        check("cold_icMiss", icMiss_o, 1);
        check("cold_instValid", instValid_o, 0);
        check("cold_reqValid", memReqValid_o, 1);
        check("cold_reqAddr", memReqAddr_o, 27'h80);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_reqAddr", memReqAddr_o, 27'h80);
            check("stall_reqValid", memReqValid_o, 1);
        end
        handshake();
        check("wait_reqValid", memReqValid_o, 0);
        check("wait_icMiss", icMiss_o, 1);
        respond(27'h81, mkLine(32'hC0));
        check("badaddr_icMiss", icMiss_o, 1);
        check("badaddr_reqValid", memReqValid_o, 0);
        respond(27'h80, mkLine(32'hA0));
        check("fill_icMiss", icMiss_o, 0);

        fetch(32'h1000, 4'hF);
        check("hit_instValid", instValid_o, 4'hF);
        check("hit_inst", inst_o, 128'h000000A3_000000A2_000000A1_000000A0);
        check("hit_icMiss", icMiss_o, 0);

        fetch(32'h1014, 4'hF);
        check("trunc_instValid", instValid_o, 4'b0111);
        check("trunc_inst", inst_o, 128'h00000000_000000A7_000000A6_000000A5);

        fetch(32'h1000, 4'b0011);
        check("mask_instValid", instValid_o, 4'b0011);

        tick();
        check("noreq_instValid", instValid_o, 0);

        // invalidate in the lookup cycle still sees the old line
        inv_i = 1'b1; invIndex_i = 6'd0;
        fetch(32'h1000, 4'hF);
        inv_i = 1'b0;
        check("invsame_instValid", instValid_o, 4'hF);
        fetch(32'h1000, 4'hF);
        check("invafter_icMiss", icMiss_o, 1);
        check("invafter_instValid", instValid_o, 0);
        handshake();
        respond(27'h80, mkLine(32'hA0));
        fetch(32'h1000, 4'hF);
        check("refill_instValid", instValid_o, 4'hF);

        // flush requested while a fill is outstanding
        fetch(32'h2020, 4'hF);
        check("fl_icMiss", icMiss_o, 1);
        check("fl_reqAddr", memReqAddr_o, 27'h101);
        handshake();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fl_wait_icMiss", icMiss_o, 1);
        respond(27'h101, mkLine(32'hB0));
        busyBad = 0;
        pulses  = 0;
        for (int i = 0; i < 64; i++) begin
            if (icMiss_o !== 1'b1) busyBad++;
            if (flushDone_o === 1'b1) pulses++;
            tick();
        end
        check("fl_busy_cycles", busyBad, 0);
        check("fl_early_done", pulses, 0);
        check("fl_done", flushDone_o, 1);
        check("fl_end_icMiss", icMiss_o, 0);
        tick();
        check("fl_done_pulse", flushDone_o, 0);
        fetch(32'h1000, 4'hF);
        check("fl_refetch_miss", icMiss_o, 1);
        check("fl_refetch_inv", instValid_o, 0);

        // invalidate racing the fill of the same set
        handshake();
        inv_i = 1'b1; invIndex_i = 6'd0;
        respond(27'h80, mkLine(32'hA0));
        inv_i = 1'b0;
        check("race_icMiss", icMiss_o, 0);
        fetch(32'h1000, 4'hF);
        check("race_miss", icMiss_o, 1);
        check("race_instValid", instValid_o, 0);

        // reset while waiting for a response
        handshake();
        check("rw_icMiss", icMiss_o, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_icMiss", icMiss_o, 0);
        check("arst_reqAddr", memReqAddr_o, 0);
        check("arst_reqValid", memReqValid_o, 0);
        check("arst_instValid", instValid_o, 0);
        check("arst_inst", inst_o, 0);
        check("arst_flushDone", flushDone_o, 0);
        tick();
        reset = 1'b1;
        tick();
        respond(27'h80, mkLine(32'hA0));
        check("stale_icMiss", icMiss_o, 0);
        check("stale_reqValid", memReqValid_o, 0);
        fetch(32'h1000, 4'hF);
        check("stale_refetch_miss", icMiss_o, 1);
        check("stale_refetch_inv", instValid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
